// File: rtl/por_reset_pkg.sv
// Shared types and default timing for the power-on reset sequencer.
// Stage durations are in clk_osc_100k cycles, counted from each stage's rise cycle.
package por_reset_pkg;

   localparam int CNT_W_DEF  = 5;
   localparam int T_PRE_DEF  = 4;
   localparam int T_OTP_DEF  = 3;
   localparam int T_RSTZ_DEF = 6;
   localparam int T_RDY_DEF  = 13;

   typedef enum logic [2:0] {
      S_PRE  = 3'd0,
      S_OTP  = 3'd1,
      S_RSTZ = 3'd2,
      S_RDY  = 3'd3,
      S_DONE = 3'd4
   } seq_state_e;

   typedef struct packed {
      logic rst_otp;
      logic rstz_i2c_reg;
      logic rstz_otp_100k;
      logic otp_rdy;
      logic reset_timer_done;
   } seq_out_t;

   // Stages are cumulative: each state keeps every release of the states before it.
   function automatic seq_out_t state_outputs(input seq_state_e s);
      seq_out_t o;
      o = '0;
      case (s)
         S_OTP: begin
            o.rst_otp = 1'b1;
         end
         S_RSTZ: begin
            o.rst_otp       = 1'b1;
            o.rstz_i2c_reg  = 1'b1;
            o.rstz_otp_100k = 1'b1;
         end
         S_RDY: begin
            o.rst_otp       = 1'b1;
            o.rstz_i2c_reg  = 1'b1;
            o.rstz_otp_100k = 1'b1;
            o.otp_rdy       = 1'b1;
         end
         S_DONE: begin
            o = '1;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/por_reset_sequencer_timer.sv
// Stage timer for the reset sequencer: up-counter with clear, hold and
// terminal-count compare. Saturates at the terminal count, never wraps.
module rst_seq_timer
   import por_reset_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_osc_100k,
   input  logic             porz,
   input  logic             clr,
   input  logic             hold,
   input  logic [CNT_W-1:0] tc_val,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_osc_100k or negedge porz) begin
      if (!porz) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (!hold && !tc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc = (cnt == tc_val);

endmodule

// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: after porz releases, steps through the staged
// OTP / I2C reset releases and ready flags with fixed cycle spacing.
//
// state  | meaning
// S_PRE  | all outputs low, waiting T_PRE cycles after release
// S_OTP  | rst_otp high for T_OTP cycles
// S_RSTZ | rstz_i2c_reg / rstz_otp_100k released for T_RSTZ cycles
// S_RDY  | otp_rdy high for T_RDY cycles
// S_DONE | reset_timer_done high, sticky until porz or soft_reset
module por_reset_sequencer
   import por_reset_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int T_PRE  = T_PRE_DEF,
   parameter int T_OTP  = T_OTP_DEF,
   parameter int T_RSTZ = T_RSTZ_DEF,
   parameter int T_RDY  = T_RDY_DEF
) (
   input  logic       clk_osc_100k,
   input  logic       porz,
   input  logic       soft_reset,
   input  logic       seq_hold,
   output logic       rst_otp,
   output logic       rstz_i2c_reg,
   output logic       rstz_otp_100k,
   output logic       otp_rdy,
   output logic       reset_timer_done,
   output logic [2:0] seq_state
);

   if (T_PRE < 1 || T_PRE >= 2**CNT_W) begin : g_bad_t_pre
      $fatal(1, "por_reset_sequencer: T_PRE out of range for CNT_W");
   end
   if (T_OTP < 1 || T_OTP >= 2**CNT_W) begin : g_bad_t_otp
      $fatal(1, "por_reset_sequencer: T_OTP out of range for CNT_W");
   end
   if (T_RSTZ < 1 || T_RSTZ >= 2**CNT_W) begin : g_bad_t_rstz
      $fatal(1, "por_reset_sequencer: T_RSTZ out of range for CNT_W");
   end
   if (T_RDY < 1 || T_RDY >= 2**CNT_W) begin : g_bad_t_rdy
      $fatal(1, "por_reset_sequencer: T_RDY out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] TC_PRE  = CNT_W'(T_PRE - 1);
   localparam logic [CNT_W-1:0] TC_OTP  = CNT_W'(T_OTP - 1);
   localparam logic [CNT_W-1:0] TC_RSTZ = CNT_W'(T_RSTZ - 1);
   localparam logic [CNT_W-1:0] TC_RDY  = CNT_W'(T_RDY - 1);

   seq_state_e       state_q;
   seq_state_e       state_d;
   seq_out_t         out_q;
   logic [CNT_W-1:0] tc_val;
   logic             tc;
   logic             legal;
   logic             tmr_clr;

   always_ff @(posedge clk_osc_100k or negedge porz) begin
      if (!porz) begin
         state_q <= S_PRE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tc_val  = TC_PRE;
      legal   = 1'b1;
      case (state_q)
         S_PRE: begin
            tc_val = TC_PRE;
            if (tc) state_d = S_OTP;
         end
         S_OTP: begin
            tc_val = TC_OTP;
            if (tc) state_d = S_RSTZ;
         end
         S_RSTZ: begin
            tc_val = TC_RSTZ;
            if (tc) state_d = S_RDY;
         end
         S_RDY: begin
            tc_val = TC_RDY;
            if (tc) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            legal   = 1'b0;
            state_d = S_PRE;
         end
      endcase

      // Hold freezes a legal state only; an illegal encoding always recovers.
      if (soft_reset) begin
         state_d = S_PRE;
      end else if (seq_hold && legal) begin
         state_d = state_q;
      end
   end

   assign tmr_clr = soft_reset || (state_d != state_q) || (state_q == S_DONE);

   rst_seq_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_osc_100k (clk_osc_100k),
      .porz         (porz),
      .clr          (tmr_clr),
      .hold         (seq_hold),
      .tc_val       (tc_val),
      .tc           (tc)
   );

   // Outputs are flopped from the next state so they track state_q exactly.
   always_ff @(posedge clk_osc_100k or negedge porz) begin
      if (!porz) begin
         out_q <= '0;
      end else begin
         out_q <= state_outputs(state_d);
      end
   end

   assign rst_otp          = out_q.rst_otp;
   assign rstz_i2c_reg     = out_q.rstz_i2c_reg;
   assign rstz_otp_100k    = out_q.rstz_otp_100k;
   assign otp_rdy          = out_q.otp_rdy;
   assign reset_timer_done = out_q.reset_timer_done;
   assign seq_state        = state_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed bench for por_reset_sequencer: default timing instance plus a
// short-duration override instance sharing the clock and control inputs.
`timescale 1ns/1ps
module tb_por_reset_sequencer;

   logic       clk_osc_100k = 1'b0;
   logic       porz;
   logic       porz2;
   logic       soft_reset;
   logic       seq_hold;

   logic       rst_otp, rstz_i2c_reg, rstz_otp_100k, otp_rdy, reset_timer_done;
   logic [2:0] seq_state;
   logic       rst_otp2, rstz_i2c_reg2, rstz_otp_100k2, otp_rdy2, reset_timer_done2;
   logic [2:0] seq_state2;

   int checks = 0;
   int errors = 0;

   always #5000 clk_osc_100k = ~clk_osc_100k;

   por_reset_sequencer u_dut (
      .clk_osc_100k     (clk_osc_100k),
      .porz             (porz),
      .soft_reset       (soft_reset),
      .seq_hold         (seq_hold),
      .rst_otp          (rst_otp),
      .rstz_i2c_reg     (rstz_i2c_reg),
      .rstz_otp_100k    (rstz_otp_100k),
      .otp_rdy          (otp_rdy),
      .reset_timer_done (reset_timer_done),
      .seq_state        (seq_state)
   );

   por_reset_sequencer #(
      .T_PRE  (2),
      .T_OTP  (1),
      .T_RSTZ (1),
      .T_RDY  (1)
   ) u_dut_short (
      .clk_osc_100k     (clk_osc_100k),
      .porz             (porz2),
      .soft_reset       (soft_reset),
      .seq_hold         (seq_hold),
      .rst_otp          (rst_otp2),
      .rstz_i2c_reg     (rstz_i2c_reg2),
      .rstz_otp_100k    (rstz_otp_100k2),
      .otp_rdy          (otp_rdy2),
      .reset_timer_done (reset_timer_done2),
      .seq_state        (seq_state2)
   );

   wire [4:0] obs1 = {reset_timer_done, otp_rdy, rstz_otp_100k, rstz_i2c_reg, rst_otp};
   wire [4:0] obs2 = {reset_timer_done2, otp_rdy2, rstz_otp_100k2, rstz_i2c_reg2, rst_otp2};

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_osc_100k);
      #1;
   endtask

   // Expected output vector n cycles after cycle 0 given each stage's rise cycle.
   function automatic logic [4:0] exp_vec(input int n, input int ro, input int rz,
                                          input int rr, input int rd);
      return {n >= rd, n >= rr, n >= rz, n >= rz, n >= ro};
   endfunction

   task automatic run_tl(input string tag, input bit short_dut, input int from, input int to,
                         input int ro, input int rz, input int rr, input int rd);
      for (int n = from; n <= to; n++) begin
         chk($sformatf("%s@%0d", tag, n), {3'b0, short_dut ? obs2 : obs1},
             {3'b0, exp_vec(n, ro, rz, rr, rd)});
         if (n < to) tick();
      end
   endtask

   initial begin
      porz       = 1'b0;
      porz2      = 1'b0;
      soft_reset = 1'b0;
      seq_hold   = 1'b0;

      // Held in porz: everything low, state S_PRE.
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("por_low_out", {3'b0, obs1}, 8'h00);
      end
      chk("por_low_state", {5'b0, seq_state}, 8'd0);
      chk("por_low_out2", {3'b0, obs2}, 8'h00);

      // Default timeline: 4, 7, 13, 26.
      porz = 1'b1;
      run_tl("base", 1'b0, 0, 30, 4, 7, 13, 26);
      chk("base_done_state", {5'b0, seq_state}, 8'd4);

      // porz drop at cycle 10 for two cycles, then full restart.
      porz = 1'b0;
      tick();
      porz = 1'b1;
      run_tl("pre_drop", 1'b0, 0, 10, 4, 7, 13, 26);
      porz = 1'b0;
      #1;
      chk("drop_async_out", {3'b0, obs1}, 8'h00);
      chk("drop_async_state", {5'b0, seq_state}, 8'd0);
      tick();
      chk("drop_low1", {3'b0, obs1}, 8'h00);
      tick();
      chk("drop_low2", {3'b0, obs1}, 8'h00);
      porz = 1'b1;
      run_tl("post_drop", 1'b0, 0, 30, 4, 7, 13, 26);

      // soft_reset pulse while in S_DONE.
      soft_reset = 1'b1;
      tick();
      chk("soft_done_out", {3'b0, obs1}, 8'h00);
      chk("soft_done_state", {5'b0, seq_state}, 8'd0);
      soft_reset = 1'b0;
      run_tl("soft_restart", 1'b0, 0, 30, 4, 7, 13, 26);

      // seq_hold over posedges 9..13 inside S_RSTZ: otp_rdy 18, done 31.
      soft_reset = 1'b1;
      tick();
      soft_reset = 1'b0;
      run_tl("hold_a", 1'b0, 0, 9, 4, 7, 18, 31);
      seq_hold = 1'b1;
      tick();
      run_tl("hold_b", 1'b0, 10, 14, 4, 7, 18, 31);
      chk("hold_state", {5'b0, seq_state}, 8'd2);
      seq_hold = 1'b0;
      tick();
      run_tl("hold_c", 1'b0, 15, 33, 4, 7, 18, 31);

      // soft_reset together with seq_hold in S_OTP: soft_reset wins.
      soft_reset = 1'b1;
      tick();
      soft_reset = 1'b0;
      run_tl("sh_a", 1'b0, 0, 5, 4, 7, 13, 26);
      chk("sh_otp_state", {5'b0, seq_state}, 8'd1);
      soft_reset = 1'b1;
      seq_hold   = 1'b1;
      tick();
      chk("sh_out", {3'b0, obs1}, 8'h00);
      chk("sh_state", {5'b0, seq_state}, 8'd0);
      tick();
      chk("sh_out_again", {3'b0, obs1}, 8'h00);
      soft_reset = 1'b0;
      seq_hold   = 1'b0;
      run_tl("sh_restart", 1'b0, 0, 14, 4, 7, 13, 26);

      // Short-duration instance: rises at 2, 3, 4, 5.
      porz2 = 1'b1;
      run_tl("short", 1'b1, 0, 8, 2, 3, 4, 5);
      chk("short_done_state", {5'b0, seq_state2}, 8'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/por_reset_sequencer.md
Name: por_reset_sequencer

Overview:
- Generator side of the power-on reset protocol: after porz releases, drives the staged reset and ready outputs in fixed order with exact cycle spacing.
- Outputs in order: rst_otp, then rstz_i2c_reg and rstz_otp_100k, then otp_rdy, then reset_timer_done.
- Sits in the always-on 100 kHz domain and feeds the OTP controller, the I2C register file and the boot logic.
- Its output timing is exactly the sequence the boot/reset assertion interface checks.

Parameters:
- T_PRE, 4, cycles with all outputs low after porz release (first cycle of porz high included).
- T_OTP, 3, cycles with only rst_otp high (the rise cycle included).
- T_RSTZ, 6, cycles with rst_otp, rstz_i2c_reg and rstz_otp_100k high and otp_rdy low (the rise cycle included).
- T_RDY, 13, cycles with otp_rdy high and reset_timer_done low (the rise cycle included).
- CNT_W, 5, width of the stage counter; must satisfy 2**CNT_W > max(T_*).

Ports:
- clk_osc_100k  input  1  100 kHz always-on clock.
- porz  input  1  asynchronous active-low power-on reset. Assertion is asynchronous. Deassertion is already synchronized upstream.
- soft_reset  input  1  synchronous active-high restart of the sequence.
- seq_hold  input  1  synchronous active-high freeze of the stage counter (test use).
- rst_otp  output  1  OTP reset release, stage 1.
- rstz_i2c_reg  output  1  I2C register file reset release, active-low reset, stage 2.
- rstz_otp_100k  output  1  OTP 100 kHz logic reset release, active-low reset, stage 2.
- otp_rdy  output  1  OTP ready, stage 3.
- reset_timer_done  output  1  sequence complete, stage 4.
- seq_state  output  3  current FSM state encoding, for debug.

Behaviour:
- All outputs are registered. While porz=0, every output is 0, seq_state=S_PRE and the counter is 0.
- Cycle 0 is the first posedge at which porz is sampled 1. The default timeline is:
  - cycles 0–3: all outputs 0;
  - cycle 4: rst_otp=1;
  - cycle 7: rstz_i2c_reg=1 and rstz_otp_100k=1;
  - cycle 13: otp_rdy=1;
  - cycle 26: reset_timer_done=1.
- General rule: each stage lasts T_x cycles, counted from its own rise cycle.
- FSM states, one-hot-free binary, encoded on seq_state:
  - S_PRE=0: counter runs 0..T_PRE-1. At the terminal count, go to S_OTP.
  - S_OTP=1: rst_otp=1. After T_OTP cycles, go to S_RSTZ.
  - S_RSTZ=2: rst_otp=1, rstz_i2c_reg=1, rstz_otp_100k=1. After T_RSTZ cycles, go to S_RDY.
  - S_RDY=3: additionally otp_rdy=1. After T_RDY cycles, go to S_DONE.
  - S_DONE=4: all five outputs 1. Terminal and sticky until porz or soft_reset.
- Output values are a pure function of the registered state. On every transition the counter clears to 0.
- Outputs are monotonic: no output ever deasserts except via porz or soft_reset.
- soft_reset=1 at any posedge, in any state:
  - next state is S_PRE, counter is 0, and all outputs are 0 on the following cycle;
  - the cycle soft_reset is sampled 0 again counts as cycle 0 of a new sequence.
- seq_hold=1: state and counter hold and outputs are unchanged. soft_reset overrides seq_hold.
- porz falling mid-sequence forces all outputs 0 immediately (asynchronously). The sequence restarts from cycle 0 on release.
- Simultaneous terminal count and seq_hold: hold wins, and the transition happens on the first unheld terminal cycle.
- The counter never wraps. Terminal compare is counter == T_x-1, evaluated with CNT_W-bit widths.
- Illegal seq_state values (5–7) recover to S_PRE with all outputs 0 on the next cycle.
- Elaboration check: any T_x < 1 or T_x >= 2**CNT_W is a fatal error.

Decomposition:
- Package por_reset_pkg holds:
  - the state enum typedef;
  - default stage durations T_PRE/T_OTP/T_RSTZ/T_RDY as localparam constants;
  - the CNT_W default.
- One natural sub-module, rst_seq_timer: CNT_W up-counter with clear, hold and terminal-count compare.

Test Plan:
- porz low 5 cycles then high, no soft_reset -> rst_otp rises at cycle 4, rstz_* at 7, otp_rdy at 13, reset_timer_done at 26. Assertion interface reports pass, zero fails.
- porz dropped at cycle 10 for 2 cycles -> all outputs 0 during low. After release, full timeline again with rst_otp at new cycle 4.
- soft_reset pulsed 1 cycle while in S_DONE -> all outputs 0 next cycle. reset_timer_done returns 26 cycles after soft_reset deasserts.
- seq_hold high for 5 cycles during S_RSTZ (starting cycle 9) -> otp_rdy delayed to cycle 18, reset_timer_done to 31, no output glitches.
- soft_reset and seq_hold both high during S_OTP -> sequence restarts (soft_reset wins). seq_state reads 0.
- Parameter override T_PRE=2, T_OTP=1, T_RSTZ=1, T_RDY=1 -> rise cycles 2, 3, 4, 5.
